// File: rtl/rv16_pkg.sv
// Shared widths and the pending-write record used by the writeback buffer.
// Entries are packed as {dst, data}, with the register index in the upper bits.
package rv16_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Two-push / one-pop circular buffer. Push port a is written before port b when
// both fire. The raw entry array is exposed so the parent can search pending writes.
module wb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_a,
    input  logic [W-1:0]               data_a,
    input  logic                       push_b,
    input  logic [W-1:0]               data_b,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [CW-1:0]              count,
    output logic [PW-1:0]              rd_ptr,
    output logic [DEPTH-1:0][W-1:0]    entries
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] wr_b_slot;

    // Port b lands one slot further on when port a also pushes this cycle.
    assign wr_b_slot = push_a ? wr_ptr_reg + PW'(1) : wr_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (push_a) mem[wr_ptr_reg] <= data_a;
            if (push_b) mem[wr_b_slot]  <= data_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PW'(push_a) + PW'(push_b);
            rd_ptr_reg <= rd_ptr_reg + PW'(pop);
            count_reg  <= count_reg + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    assign head   = mem[rd_ptr_reg];
    assign count  = count_reg;
    assign rd_ptr = rd_ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entries
            assign entries[gi] = mem[gi];
        end
    endgenerate
endmodule

// File: rtl/writeback_buffer.sv
// Register-file write port: merges load and ALU results into an in-order queue
// and drains one write per cycle. Optional bypass lookup enabled by WB_BYPASS_EN.
module writeback_buffer #(
    parameter int DATA_W = rv16_pkg::DATA_W,
    parameter int ADDR_W = rv16_pkg::REG_ADDR_W,
    parameter int DEPTH  = rv16_pkg::WB_DEPTH,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memValid,
    output logic              memReady,
    input  logic [ADDR_W-1:0] memReg,
    input  logic [DATA_W-1:0] memData,
    input  logic              aluValid,
    output logic              aluReady,
    input  logic [ADDR_W-1:0] aluReg,
    input  logic [DATA_W-1:0] aluData,
    output logic              regWrite_en,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    input  logic [ADDR_W-1:0] bypReg,
    output logic              bypHit,
    output logic [DATA_W-1:0] bypData
);
    localparam int W   = ADDR_W + DATA_W;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW1 = CW + 1;

    logic                     push_mem;
    logic                     push_alu;
    logic                     pop;
    logic [W-1:0]             head;
    logic [PW-1:0]            rd_ptr;
    logic [DEPTH-1:0][W-1:0]  fifo_entries;
    logic [CW1-1:0]           alu_need;
    logic                     wen_reg;
    logic [ADDR_W-1:0]        wreg_reg;
    logic [DATA_W-1:0]        wdata_reg;

    // Readiness looks only at registered occupancy; a same-cycle pop earns no credit.
    assign alu_need = {1'b0, count} + CW1'(memValid);
    assign memReady = rst_n && (count < CW'(DEPTH));
    assign aluReady = rst_n && (alu_need < CW1'(DEPTH));
    assign push_mem = memValid && memReady;
    assign push_alu = aluValid && aluReady;
    assign pop      = (count != '0);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    wb_fifo #(.W(W), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (push_mem),
        .data_a  ({memReg, memData}),
        .push_b  (push_alu),
        .data_b  ({aluReg, aluData}),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .rd_ptr  (rd_ptr),
        .entries (fifo_entries)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_reg   <= 1'b0;
            wreg_reg  <= '0;
            wdata_reg <= '0;
        end else if (pop) begin
            wen_reg   <= 1'b1;
            wreg_reg  <= head[W-1 -: ADDR_W];
            wdata_reg <= head[DATA_W-1:0];
        end else begin
            wen_reg   <= 1'b0;
        end
    end

    assign regWrite_en = wen_reg;
    assign writeReg    = wreg_reg;
    assign writeData   = wdata_reg;

`ifdef WB_BYPASS_EN
    logic [DEPTH-1:0]             age_match;
    logic [DEPTH-1:0][DATA_W-1:0] age_data;
    logic                         byp_hit_next;
    logic [DATA_W-1:0]            byp_data_next;

    // Age gi is the gi-th oldest queued entry; larger ages are younger.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] slot;
            assign slot          = rd_ptr + PW'(gi);
            assign age_match[gi] = (CW'(gi) < count) &&
                                   (fifo_entries[slot][W-1 -: ADDR_W] == bypReg);
            assign age_data[gi]  = fifo_entries[slot][DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        byp_hit_next  = 1'b0;
        byp_data_next = '0;
        if (wen_reg && (wreg_reg == bypReg)) begin
            byp_hit_next  = 1'b1;
            byp_data_next = wdata_reg;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (age_match[k]) begin
                byp_hit_next  = 1'b1;
                byp_data_next = age_data[k];
            end
        end
    end

    assign bypHit  = byp_hit_next;
    assign bypData = byp_data_next;
`else
    logic unused_byp;
    assign unused_byp = ^{bypReg, rd_ptr, fifo_entries};
    assign bypHit     = 1'b0;
    assign bypData    = '0;
`endif
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer; bypass checks depend on WB_BYPASS_EN.
module tb_writeback_buffer;
    import rv16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memValid, aluValid;
    logic        memReady, aluReady;
    logic [2:0]  memReg, aluReg, bypReg;
    logic [15:0] memData, aluData;
    logic        regWrite_en;
    logic [2:0]  writeReg;
    logic [15:0] writeData;
    logic [2:0]  count;
    logic        empty, full, bypHit;
    logic [15:0] bypData;

    int vectors = 0;
    int miscompares = 0;

    writeback_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
        .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
        .regWrite_en(regWrite_en), .writeReg(writeReg), .writeData(writeData),
        .count(count), .empty(empty), .full(full),
        .bypReg(bypReg), .bypHit(bypHit), .bypData(bypData)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        memValid = 0; aluValid = 0;
        memReg = 0; aluReg = 0; memData = 0; aluData = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bypReg = 0;
        rst_n = 0;
        tick(); tick();
        #1;
        vectors++;
        if (count !== 3'd0 || regWrite_en !== 1'b0 || writeReg !== 3'd0 || writeData !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: got count=%0d wen=%b reg=%0d data=%h, required 0/0/0/0000",
                     count, regWrite_en, writeReg, writeData);
        end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got empty=%b full=%b, required 1/0", empty, full);
        end
        memValid = 1; aluValid = 1;
        #1;
        vectors++;
        if (memReady !== 1'b0 || aluReady !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got memReady=%b aluReady=%b, required 0/0", memReady, aluReady);
        end
        idle_inputs();
        rst_n = 1;
        #1;
        vectors++;
        if (memReady !== 1'b1 || aluReady !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got memReady=%b aluReady=%b, required 1/1", memReady, aluReady);
        end
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_single_alu();
        aluValid = 1; aluReg = 3'd3; aluData = 16'h1234;
        tick();
        idle_inputs();
        vectors++;
        if (regWrite_en !== 1'b0 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL single_edge1: got wen=%b count=%0d, required 0/1", regWrite_en, count);
        end
        tick();
        vectors++;
        if (regWrite_en !== 1'b1 || writeReg !== 3'd3 || writeData !== 16'h1234 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL single_write: got wen=%b reg=%0d data=%h count=%0d, required 1/3/1234/0",
                     regWrite_en, writeReg, writeData, count);
        end
        tick();
        vectors++;
        if (regWrite_en !== 1'b0 || writeReg !== 3'd3 || writeData !== 16'h1234) begin
            miscompares++;
            $display("FAIL single_hold: got wen=%b reg=%0d data=%h, required 0/3/1234",
                     regWrite_en, writeReg, writeData);
        end
        $display("test_single_alu: write r3=1234 observed");
    endtask

    task automatic test_dual_push();
        memValid = 1; memReg = 3'd1; memData = 16'hAAAA;
        aluValid = 1; aluReg = 3'd2; aluData = 16'h5555;
        tick();
        idle_inputs();
        vectors++;
        if (count !== 3'd2 || regWrite_en !== 1'b0) begin
            miscompares++;
            $display("FAIL dual_count: got count=%0d wen=%b, required 2/0", count, regWrite_en);
        end
        tick();
        vectors++;
        if (regWrite_en !== 1'b1 || writeReg !== 3'd1 || writeData !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL dual_first: got wen=%b reg=%0d data=%h, required 1/1/aaaa",
                     regWrite_en, writeReg, writeData);
        end
        tick();
        vectors++;
        if (regWrite_en !== 1'b1 || writeReg !== 3'd2 || writeData !== 16'h5555) begin
            miscompares++;
            $display("FAIL dual_second: got wen=%b reg=%0d data=%h, required 1/2/5555",
                     regWrite_en, writeReg, writeData);
        end
        tick();
        vectors++;
        if (regWrite_en !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL dual_idle: got wen=%b count=%0d, required 0/0", regWrite_en, count);
        end
        $display("test_dual_push: r1=aaaa then r2=5555 observed");
    endtask

    task automatic test_back_to_back();
        wb_entry_t exp_q[$];
        int idx = 0;
        int seen = 0;
        bit acc;
        for (int i = 0; i < 6; i++) exp_q.push_back('{dst: 3'(i), data: 16'hB000 + 16'(i)});
        for (int cyc = 0; cyc < 30 && seen < 6; cyc++) begin
            if (idx < 6) begin
                aluValid = 1; aluReg = exp_q[idx].dst; aluData = exp_q[idx].data;
            end else begin
                aluValid = 0;
            end
            #1;
            acc = aluValid && aluReady;
            tick();
            if (acc) idx++;
            vectors++;
            if (count > 3'd4) begin
                miscompares++;
                $display("FAIL b2b_count: got count=%0d, required <=4", count);
            end
            if (regWrite_en === 1'b1) begin
                vectors++;
                if (writeReg !== exp_q[seen].dst || writeData !== exp_q[seen].data) begin
                    miscompares++;
                    $display("FAIL b2b_write%0d: got r%0d=%h, required r%0d=%h",
                             seen, writeReg, writeData, exp_q[seen].dst, exp_q[seen].data);
                end
                $display("test_back_to_back: write %0d r%0d=%h", seen, writeReg, writeData);
                seen++;
            end
        end
        idle_inputs();
        vectors++;
        if (seen != 6) begin
            miscompares++;
            $display("FAIL b2b_total: got %0d writes, required 6", seen);
        end
        tick(); tick();
        vectors++;
        if (regWrite_en !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL b2b_extra: got wen=%b count=%0d, required 0/0", regWrite_en, count);
        end
    endtask

    task automatic test_near_full();
        logic [2:0] exp_reg [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        memValid = 1; memReg = 3'd1; memData = 16'h0101;
        aluValid = 1; aluReg = 3'd2; aluData = 16'h0102;
        tick();
        memReg = 3'd3; memData = 16'h0103;
        aluReg = 3'd4; aluData = 16'h0104;
        #1;
        vectors++;
        if (count !== 3'd2 || aluReady !== 1'b1) begin
            miscompares++;
            $display("FAIL nf_count2: got count=%0d aluReady=%b, required 2/1", count, aluReady);
        end
        tick();
        memReg = 3'd5; memData = 16'h0105;
        aluReg = 3'd6; aluData = 16'h0106;
        #1;
        vectors++;
        if (count !== 3'd3 || memReady !== 1'b1 || aluReady !== 1'b0) begin
            miscompares++;
            $display("FAIL nf_ready: got count=%0d memReady=%b aluReady=%b, required 3/1/0",
                     count, memReady, aluReady);
        end
        tick();
        memValid = 0;
        #1;
        vectors++;
        if (count !== 3'd3 || full !== 1'b0 || aluReady !== 1'b1) begin
            miscompares++;
            $display("FAIL nf_pop_credit: got count=%0d full=%b aluReady=%b, required 3/0/1",
                     count, full, aluReady);
        end
        tick();
        idle_inputs();
        // Writes r1 and r2 already drained during the fill; collect the rest in order.
        for (int k = 2; k < 6; k++) begin
            vectors++;
            if (regWrite_en !== 1'b1 || writeReg !== exp_reg[k] || writeData !== {13'h0020, exp_reg[k]}) begin
                miscompares++;
                $display("FAIL nf_drain%0d: got wen=%b r%0d=%h, required 1 r%0d=%h",
                         k, regWrite_en, writeReg, writeData, exp_reg[k], {13'h0020, exp_reg[k]});
            end
            $display("test_near_full: write r%0d=%h", writeReg, writeData);
            tick();
        end
        vectors++;
        if (regWrite_en !== 1'b0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL nf_empty: got wen=%b empty=%b, required 0/1", regWrite_en, empty);
        end
    endtask

    task automatic test_bypass();
        bypReg = 3'd5;
        memValid = 1; memReg = 3'd5; memData = 16'h0001;
        aluValid = 1; aluReg = 3'd5; aluData = 16'h0002;
        tick();
        idle_inputs();
        #1;
`ifdef WB_BYPASS_EN
        vectors++;
        if (bypHit !== 1'b1 || bypData !== 16'h0002) begin
            miscompares++;
            $display("FAIL byp_queued: got hit=%b data=%h, required 1/0002", bypHit, bypData);
        end
        bypReg = 3'd4;
        #1;
        vectors++;
        if (bypHit !== 1'b0) begin
            miscompares++;
            $display("FAIL byp_miss: got hit=%b, required 0", bypHit);
        end
        bypReg = 3'd5;
        tick();
        vectors++;
        if (bypHit !== 1'b1 || bypData !== 16'h0002) begin
            miscompares++;
            $display("FAIL byp_one_out: got hit=%b data=%h, required 1/0002", bypHit, bypData);
        end
        tick();
        vectors++;
        if (bypHit !== 1'b1 || bypData !== 16'h0002 || regWrite_en !== 1'b1) begin
            miscompares++;
            $display("FAIL byp_outstage: got hit=%b data=%h wen=%b, required 1/0002/1",
                     bypHit, bypData, regWrite_en);
        end
        tick();
        vectors++;
        if (bypHit !== 1'b0) begin
            miscompares++;
            $display("FAIL byp_drained: got hit=%b, required 0", bypHit);
        end
`else
        vectors++;
        if (bypHit !== 1'b0 || bypData !== 16'h0000) begin
            miscompares++;
            $display("FAIL byp_disabled: got hit=%b data=%h, required 0/0000", bypHit, bypData);
        end
        tick(); tick(); tick();
`endif
        $display("test_bypass: done");
    endtask

    task automatic test_reset_mid();
        memValid = 1; memReg = 3'd1; memData = 16'hC001;
        aluValid = 1; aluReg = 3'd2; aluData = 16'hC002;
        tick();
        memReg = 3'd3; memData = 16'hC003;
        aluReg = 3'd4; aluData = 16'hC004;
        tick();
        idle_inputs();
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL mid_fill: got count=%0d, required 3", count);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        vectors++;
        if (count !== 3'd0 || regWrite_en !== 1'b0 || writeReg !== 3'd0 || writeData !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got count=%0d wen=%b reg=%0d data=%h, required 0/0/0/0000",
                     count, regWrite_en, writeReg, writeData);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (regWrite_en !== 1'b0 || count !== 3'd0) begin
                miscompares++;
                $display("FAIL mid_stale%0d: got wen=%b count=%0d, required 0/0", k, regWrite_en, count);
            end
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual_push();
        test_back_to_back();
        test_near_full();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
